fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: owns the PC, issues requests to instruction memory over a valid/ready channel, pairs in-order responses with their PCs, buffers them, and presents one `if_t` per cycle to the IF/ID boundary. It sits directly upstream of decode. It honours the decode-stage `stall`, and honours `redirect` from EX for taken branches and jumps.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_fifo.sv | 81 ++++++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   NOP_INSTR     : instruction used to fill bubbles at the IF/ID boundary
//   if_t          : {isValid, instr, pc} handed to decode (65 bits)
//   fetch_entry_t : {instr, pc} pair held in the instruction buffer
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        isValid;
    logic [31:0] instr;
    logic [31:0] pc;
  } if_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO used by the fetch stage (tag FIFO and instruction
// buffer). Head is visible combinationally on dout; flush empties it in one
// clock and takes priority over push/pop.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data (ignored when full or flushing)
//   pop           : remove head (ignored when empty or flushing)
//   flush         : discard all entries
//   dout          : current head entry
//   count         : number of stored entries
//   full, empty   : occupancy flags
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, issues fetches over a valid/ready
// channel, pairs in-order responses with their PCs (tag FIFO), buffers them
// while decode stalls, and presents one if_t per cycle to IF/ID.
//   clk, rst                        : clock, asynchronous active-high reset
//   imem_req_valid/addr/ready       : fetch request channel
//   imem_rsp_valid/data             : in-order fetch responses
//   stall                           : decode stall, holds if_out
//   redirect, redirect_pc           : flush and restart fetching
//   if_out                          : {isValid, instr, pc} to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output if_t         if_out
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(MAX_OUTSTANDING);
  localparam if_t BUBBLE = '{isValid: 1'b0, instr: NOP_INSTR, pc: 32'h0};

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;
  if_t              if_out_q, if_out_d;

  logic [CNT_W-1:0] tag_count, buf_count;
  logic             tag_full, tag_empty, buf_full, buf_empty;
  logic [31:0]      tag_head;
  fetch_entry_t     buf_head, rsp_entry;
  logic             tag_push, tag_pop, buf_push, buf_pop;

  logic [SUM_W-1:0] outstanding, credit_used;
  logic             req_fire, rsp_live, rsp_drop, rsp_accept;
  logic             unused_ok;

  // Responses still owed by memory: tagged ones plus those already orphaned
  // by a redirect.
  assign outstanding = SUM_W'(tag_count) + SUM_W'(discard_cnt_q);
  assign credit_used = outstanding + SUM_W'(buf_count);

  assign imem_req_valid = !rst && !redirect && !tag_full && (credit_used < CREDIT_LIMIT);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing owed is ignored entirely.
  assign rsp_live   = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop   = rsp_live && (discard_cnt_q != '0);
  assign rsp_accept = rsp_live && (discard_cnt_q == '0) && !tag_empty;
  assign rsp_entry  = '{instr: imem_rsp_data, pc: tag_head};

  assign if_out    = if_out_q;
  assign unused_ok = &{1'b0, buf_full, redirect_pc[1:0]};

  always_comb begin
    tag_push      = req_fire;
    tag_pop       = 1'b0;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    pc_d          = pc_q;
    discard_cnt_d = discard_cnt_q;
    if_out_d      = if_out_q;
    if (redirect) begin
      // Everything still owed by memory becomes garbage, except a response
      // landing this very cycle, which is consumed (and dropped) now.
      pc_d          = {redirect_pc[31:2], 2'b00};
      discard_cnt_d = CNT_W'(outstanding - SUM_W'(rsp_live));
      if_out_d      = BUBBLE;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp_drop) discard_cnt_d = discard_cnt_q - 1'b1;
      tag_pop = rsp_accept;
      if (!stall) begin
        if (!buf_empty) begin
          // Older buffered entries go first; a new response queues behind.
          buf_pop  = 1'b1;
          buf_push = rsp_accept;
          if_out_d = '{isValid: 1'b1, instr: buf_head.instr, pc: buf_head.pc};
        end else if (rsp_accept) begin
          if_out_d = '{isValid: 1'b1, instr: rsp_entry.instr, pc: rsp_entry.pc};
        end else begin
          if_out_d = BUBBLE;
        end
      end else begin
        buf_push = rsp_accept;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      discard_cnt_q <= '0;
      if_out_q      <= BUBBLE;
    end else begin
      pc_q          <= pc_d;
      discard_cnt_q <= discard_cnt_d;
      if_out_q      <= if_out_d;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (pc_q),
    .pop   (tag_pop),
    .flush (redirect),
    .dout  (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .din   (rsp_entry),
    .pop   (buf_pop),
    .flush (redirect),
    .dout  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with an in-order memory model whose
// response latency is selectable (1..3 cycles). Instruction at address A is ~A.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  if_t         if_out;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_out         (if_out)
  );

  // Memory model: fixed-latency pipeline, reset together with the stage.
  logic [2:0]  pv;
  logic [31:0] pa [3];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], imem_req_valid && imem_req_ready};
      pa[2] <= pa[1];
      pa[1] <= pa[0];
      pa[0] <= imem_req_addr;
    end
  end
  assign imem_rsp_valid = pv[lat-1];
  assign imem_rsp_data  = ~pa[lat-1];

  function automatic logic [64:0] exp_if(input logic v, input logic [31:0] pc);
    return v ? {1'b1, ~pc, pc} : {1'b0, 32'h0000_0013, 32'h0};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle c0 after reset release.
  task automatic apply_reset(input int latency);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    lat = latency;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    $display("reset: req_valid=%b addr=%h if_out=%h", imem_req_valid, imem_req_addr, if_out);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want 00000000", imem_req_addr);
    end
    checks++;
    if (if_out !== exp_if(1'b0, 32'h0)) begin
      errors++; $display("FAIL reset_if_out: got %h want %h", if_out, exp_if(1'b0, 32'h0));
    end
  endtask

  task automatic test_stream();
    logic [64:0] e;
    apply_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      #2;
      e = exp_if(k >= 2, 32'(4 * (k - 2)));
      $display("stream c%0d: req=%b addr=%h if_out=%h", k, imem_req_valid, imem_req_addr, if_out);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * k)) begin
        errors++; $display("FAIL stream_req c%0d: got valid=%b addr=%h want valid=1 addr=%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      checks++;
      if (if_out !== e) begin
        errors++; $display("FAIL stream_if_out c%0d: got %h want %h", k, if_out, e);
      end
    end
  endtask

  // Continues straight from test_stream; stall covers cycles c6..c9.
  task automatic test_stall();
    logic        rv  [9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [31:0] ra  [9] = '{32'h18, 0, 0, 0, 0, 32'h1C, 32'h20, 32'h24, 32'h28};
    logic [31:0] opc [9] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    logic [64:0] e;
    for (int j = 0; j < 9; j++) begin
      next_cycle();
      stall = (j < 4);
      #2;
      e = exp_if(1'b1, opc[j]);
      $display("stall s+%0d: stall=%b req=%b addr=%h if_out=%h", j, stall, imem_req_valid, imem_req_addr, if_out);
      checks++;
      if (imem_req_valid !== rv[j] || (rv[j] && imem_req_addr !== ra[j])) begin
        errors++; $display("FAIL stall_req s+%0d: got valid=%b addr=%h want valid=%b addr=%h", j, imem_req_valid, imem_req_addr, rv[j], ra[j]);
      end
      checks++;
      if (if_out !== e) begin
        errors++; $display("FAIL stall_if_out s+%0d: got %h want %h", j, if_out, e);
      end
    end
    stall = 1'b0;
  endtask

  // Latency 2: redirect in c2 with requests for 0x0 and 0x4 in flight.
  task automatic test_redirect();
    logic        rv  [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    logic [31:0] ra  [8] = '{32'h0, 32'h4, 0, 32'h100, 32'h104, 0, 32'h108, 32'h10C};
    logic        ov  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic [31:0] opc [8] = '{0, 0, 0, 0, 0, 0, 32'h100, 32'h104};
    logic [64:0] e;
    apply_reset(2);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) next_cycle();
      redirect = (j == 2);
      redirect_pc = 32'h0000_0103;
      #2;
      e = exp_if(ov[j], opc[j]);
      $display("redirect c%0d: redir=%b req=%b addr=%h if_out=%h", j, redirect, imem_req_valid, imem_req_addr, if_out);
      checks++;
      if (imem_req_valid !== rv[j] || (rv[j] && imem_req_addr !== ra[j])) begin
        errors++; $display("FAIL redirect_req c%0d: got valid=%b addr=%h want valid=%b addr=%h", j, imem_req_valid, imem_req_addr, rv[j], ra[j]);
      end
      checks++;
      if (if_out !== e) begin
        errors++; $display("FAIL redirect_if_out c%0d: got %h want %h", j, if_out, e);
      end
    end
    redirect = 1'b0;
  endtask

  // Latency 1: redirect + stall in c2 while the response for 0x4 arrives.
  task automatic test_redirect_stall();
    logic        rv  [6] = '{1, 1, 0, 1, 1, 1};
    logic [31:0] ra  [6] = '{32'h0, 32'h4, 0, 32'h40, 32'h44, 32'h48};
    logic        ov  [6] = '{0, 0, 1, 0, 0, 1};
    logic [31:0] opc [6] = '{0, 0, 32'h0, 0, 0, 32'h40};
    logic [64:0] e;
    apply_reset(1);
    for (int j = 0; j < 6; j++) begin
      if (j > 0) next_cycle();
      redirect = (j == 2);
      stall = (j == 2);
      redirect_pc = 32'h0000_0040;
      #2;
      e = exp_if(ov[j], opc[j]);
      $display("redir_stall c%0d: redir=%b stall=%b rsp=%b req=%b addr=%h if_out=%h", j, redirect, stall, imem_rsp_valid, imem_req_valid, imem_req_addr, if_out);
      checks++;
      if (imem_req_valid !== rv[j] || (rv[j] && imem_req_addr !== ra[j])) begin
        errors++; $display("FAIL redir_stall_req c%0d: got valid=%b addr=%h want valid=%b addr=%h", j, imem_req_valid, imem_req_addr, rv[j], ra[j]);
      end
      checks++;
      if (if_out !== e) begin
        errors++; $display("FAIL redir_stall_if_out c%0d: got %h want %h", j, if_out, e);
      end
    end
    redirect = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    logic        rv  [4] = '{0, 1, 1, 1};
    logic [31:0] ra  [4] = '{0, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic        ov  [4] = '{0, 0, 0, 1};
    logic [64:0] e;
    apply_reset(1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) next_cycle();
      redirect = (j == 0);
      redirect_pc = 32'hFFFF_FFFC;
      #2;
      e = exp_if(ov[j], 32'hFFFF_FFFC);
      $display("wrap c%0d: req=%b addr=%h if_out=%h", j, imem_req_valid, imem_req_addr, if_out);
      checks++;
      if (imem_req_valid !== rv[j] || (rv[j] && imem_req_addr !== ra[j])) begin
        errors++; $display("FAIL wrap_req c%0d: got valid=%b addr=%h want valid=%b addr=%h", j, imem_req_valid, imem_req_addr, rv[j], ra[j]);
      end
      checks++;
      if (if_out !== e) begin
        errors++; $display("FAIL wrap_if_out c%0d: got %h want %h", j, if_out, e);
      end
    end
    redirect = 1'b0;
  endtask

  // Latency 2: redirects in c2 (0x200) and c3 (0x300); only 0x300 survives.
  task automatic test_back_to_back();
    logic        rv [8] = '{1, 1, 0, 0, 1, 1, 0, 1};
    logic [31:0] ra [8] = '{32'h0, 32'h4, 0, 0, 32'h300, 32'h304, 0, 32'h308};
    logic [64:0] e;
    apply_reset(2);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) next_cycle();
      redirect = (j == 2 || j == 3);
      redirect_pc = (j == 2) ? 32'h0000_0200 : 32'h0000_0300;
      #2;
      e = exp_if(j == 7, 32'h300);
      $display("b2b c%0d: redir=%b req=%b addr=%h if_out=%h", j, redirect, imem_req_valid, imem_req_addr, if_out);
      checks++;
      if (imem_req_valid !== rv[j] || (rv[j] && imem_req_addr !== ra[j])) begin
        errors++; $display("FAIL b2b_req c%0d: got valid=%b addr=%h want valid=%b addr=%h", j, imem_req_valid, imem_req_addr, rv[j], ra[j]);
      end
      checks++;
      if (if_out !== e) begin
        errors++; $display("FAIL b2b_if_out c%0d: got %h want %h", j, if_out, e);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(1);
    repeat (3) next_cycle();
    #2;
    checks++;
    if (if_out !== exp_if(1'b1, 32'h4)) begin
      errors++; $display("FAIL async_pre if_out: got %h want %h", if_out, exp_if(1'b1, 32'h4));
    end
    #1;
    rst = 1'b1;
    #1;
    $display("async_rst mid-cycle: req=%b if_out=%h", imem_req_valid, if_out);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL async_req_valid: got %b want 0", imem_req_valid);
    end
    checks++;
    if (if_out.isValid !== 1'b0) begin
      errors++; $display("FAIL async_if_valid: got %b want 0", if_out.isValid);
    end
    next_cycle();
    rst = 1'b0;
    #2;
    $display("async restart c0: req=%b addr=%h", imem_req_valid, imem_req_addr);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL async_restart_req: got valid=%b addr=%h want valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
    repeat (2) next_cycle();
    #2;
    $display("async restart c2: if_out=%h", if_out);
    checks++;
    if (if_out !== exp_if(1'b1, 32'h0)) begin
      errors++; $display("FAIL async_restart_if_out: got %h want %h", if_out, exp_if(1'b1, 32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
